bp_lce_req_arbiter: RTL and testbench
=====================================

// Module: bp_lce_req_arbiter
// PURPOSE
//  Weighted round-robin scheduler merging the two per-core LCE request channels (index 0 = icache
//  LCE, index 1 = dcache LCE) onto one outgoing coherence-network request link. Each accepted
//  request goes into a 2-entry output FIFO with header, block data and source index.
//  Under contention the dcache LCE gets up to dcache_weight_p consecutive grants, then the icache
//  LCE gets one. Sits between the core's two LCEs and the tile's single LCE-request port.
// PARAMETERS
//  header_width_p   72    width of one LCE request header
//  data_width_p     512   width of one request data block (cce block width)
//  dcache_weight_p  2     max consecutive contended dcache grants before icache is served; >=1
// PORTS
//  clk_i              in   1                   clock
//  reset_n_i          in   1                   reset, asynchronous, active-low
//  lce_req_header_i   in   [1:0][header_w]     per-LCE request header
//  lce_req_data_i     in   [1:0][data_w]       per-LCE request data
//  lce_req_v_i        in   [1:0]               per-LCE request valid
//  lce_req_ready_and_o out [1:0]               per-LCE ready; a transfer occurs when v & ready_and
//  lce_req_header_o   out  header_w            FIFO-head header
//  lce_req_data_o     out  data_w              FIFO-head data
//  lce_req_src_o      out  1                   FIFO-head source (0 icache, 1 dcache)
//  lce_req_v_o        out  1                   FIFO non-empty
//  lce_req_ready_and_i in  1                   downstream ready; dequeue on v_o & ready_and_i
// BEHAVIOUR
//  Reset (async assert, sync deassert supplied externally)
//   - Clears FIFO pointers and count, streak counter cnt, and data regs to 0.
//   - v_o=0, header/data/src_o=0. ready_and_o=2'b00 while reset_n_i is low.
//   - Reset mid-operation discards all buffered entries. None appear after release.
//  Grant (combinational, only when FIFO not full)
//   - grant1 = v_i[1] & (~v_i[0] | cnt < dcache_weight_p)
//   - grant0 = v_i[0] & ~grant1
//   - ready_and_o[k] = reset_n_i & ~full & grant_k, so it depends on the other port's v_i.
//     Upstream v_i must not depend on ready_and_o.
//   - At most one input accepted per cycle. Ungranted requests stall; no drop.
//  Streak counter cnt (width clog2(dcache_weight_p+1)), updated only on an accepted transfer
//   - dcache accepted while v_i[0]=1: cnt+1, saturating at dcache_weight_p.
//   - dcache accepted while v_i[0]=0: cnt=0.
//   - icache accepted: cnt=0.
//   - No transfer: cnt holds.
//  FIFO: 2 entries {src, header, data}; wrapping 1-bit wr/rd pointers plus 2-bit count
//   - Enqueue on an accepted input. Dequeue on v_o & ready_and_i. Order preserved.
//   - Latency: accept at edge N, data visible on outputs after edge N; no input->output bypass.
//   - Full (count=2): ready_and_o=0 even if a dequeue happens the same cycle (no full pass-through).
//   - Empty: v_o=0; outputs show stale head contents, to be ignored.
//   - Simultaneous enqueue and dequeue with count=1: count stays 1, both pointers advance.
//   - Sustains 1 request/cycle when ready_and_i is held high.
//  No assertion on v_i stability; an unaccepted request may be withdrawn without effect.
// TESTING
//  1 Both v_i high continuously, ready_and_i=1, weight 2
//    -> accepts D,D,I,D,D,I; src_o = 1,1,0,1,1,0, each one cycle after its accept.
//  2 ready_and_i=0, icache pushes hdr 0x11 then 0x22
//    -> ready_and_o[0]=0 on the 3rd cycle. Raise ready_and_i: 0x11 then 0x22 out,
//       ready_and_o[0] returns the cycle after the first dequeue.
//  3 Only v_i[0] high for 5 cycles, ready_and_i=1
//    -> 5 accepts back-to-back, cnt stays 0, v_o high on cycles 2-6.
//  4 Contended: dcache granted once (cnt=1), icache drops v, dcache granted again
//    -> cnt=0; icache re-asserts -> dcache gets 2 more grants first.
//  5 FIFO holding 2 entries, pulse reset_n_i low between clock edges
//    -> v_o=0 and ready_and_o=0 immediately. After release v_o stays 0 until a new accept.
//  6 Data integrity: dcache data 0xDEAD...BEEF, icache header 0xA5A5
//    -> bit-exact on the outputs with the correct src_o; no corruption on full/empty wrap.

Source files
------------

// File: rtl/bp_lce_req_arbiter_if.sv
// LCE request bundle: two upstream request channels merged onto one outgoing link.
// slave = arbiter side, master = surrounding environment side.
interface bp_lce_req_arbiter_if #(
  parameter int unsigned header_width_p = 72,
  parameter int unsigned data_width_p   = 512
);
  logic [1:0][header_width_p-1:0] lce_req_header_i;
  logic [1:0][data_width_p-1:0]   lce_req_data_i;
  logic [1:0]                     lce_req_v_i;
  logic [1:0]                     lce_req_ready_and_o;
  logic [header_width_p-1:0]      lce_req_header_o;
  logic [data_width_p-1:0]        lce_req_data_o;
  logic                           lce_req_src_o;
  logic                           lce_req_v_o;
  logic                           lce_req_ready_and_i;

  modport slave (
    input  lce_req_header_i, lce_req_data_i, lce_req_v_i, lce_req_ready_and_i,
    output lce_req_ready_and_o, lce_req_header_o, lce_req_data_o, lce_req_src_o, lce_req_v_o
  );

  modport master (
    output lce_req_header_i, lce_req_data_i, lce_req_v_i, lce_req_ready_and_i,
    input  lce_req_ready_and_o, lce_req_header_o, lce_req_data_o, lce_req_src_o, lce_req_v_o
  );
endinterface

// File: rtl/bp_lce_req_arbiter.sv
// Weighted round-robin merge of icache (0) and dcache (1) LCE requests into a 2-entry FIFO.
// dcache wins up to dcache_weight_p consecutive contended grants, then icache gets one.
module bp_lce_req_arbiter #(
  parameter int unsigned header_width_p  = 72,
  parameter int unsigned data_width_p    = 512,
  parameter int unsigned dcache_weight_p = 2
) (
  input logic               clk_i,
  input logic               reset_n_i,
  bp_lce_req_arbiter_if.slave bus
);
  localparam int unsigned              cnt_w_lp  = $clog2(dcache_weight_p + 1);
  localparam logic [cnt_w_lp-1:0]      weight_lp = cnt_w_lp'(dcache_weight_p);

  logic [cnt_w_lp-1:0]             r_cnt;
  logic [1:0]                      r_count;
  logic                            r_wr;
  logic                            r_rd;
  logic [1:0][header_width_p-1:0]  r_hdr;
  logic [1:0][data_width_p-1:0]    r_data;
  logic [1:0]                      r_src;

  logic       w_full;
  logic       w_empty;
  logic       w_grant0;
  logic       w_grant1;
  logic [1:0] w_ready;
  logic       w_enq;
  logic       w_enq_src;
  logic       w_deq;

  // Grant never looks at the dequeue side, so a full FIFO refuses input even while draining.
  always_comb begin
    w_full    = (r_count == 2'd2);
    w_empty   = (r_count == 2'd0);
    w_grant1  = bus.lce_req_v_i[1] & (~bus.lce_req_v_i[0] | (r_cnt < weight_lp));
    w_grant0  = bus.lce_req_v_i[0] & ~w_grant1;
    w_ready   = {w_grant1, w_grant0} & {2{reset_n_i & ~w_full}};
    w_enq     = |w_ready;
    w_enq_src = w_ready[1];
    w_deq     = ~w_empty & bus.lce_req_ready_and_i;
  end

  assign bus.lce_req_ready_and_o = w_ready;
  assign bus.lce_req_v_o         = ~w_empty;
  assign bus.lce_req_header_o    = r_hdr[r_rd];
  assign bus.lce_req_data_o      = r_data[r_rd];
  assign bus.lce_req_src_o       = r_src[r_rd];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wr <= ~r_wr;
      if (w_deq) r_rd <= ~r_rd;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
    end else if (w_enq) begin
      if (w_enq_src && bus.lce_req_v_i[0])
        r_cnt <= (r_cnt == weight_lp) ? r_cnt : r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_hdr  <= '0;
      r_data <= '0;
      r_src  <= '0;
    end else if (w_enq) begin
      r_hdr[r_wr]  <= bus.lce_req_header_i[w_enq_src];
      r_data[r_wr] <= bus.lce_req_data_i[w_enq_src];
      r_src[r_wr]  <= w_enq_src;
    end
  end
endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Bench for bp_lce_req_arbiter: vector table, directed corner sequences, random vs queue model.
module tb_bp_lce_req_arbiter;
  localparam int HW = 72;
  localparam int DW = 512;
  localparam int W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bp_lce_req_arbiter_if #(.header_width_p(HW), .data_width_p(DW)) bus ();

  bp_lce_req_arbiter #(
    .header_width_p (HW),
    .data_width_p   (DW),
    .dcache_weight_p(W)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic          src;
  } ent_t;

  typedef struct {
    bit         rst;
    logic [1:0] v;
    logic       rdy;
    logic [1:0] exp_ready;
    logic       exp_vo;
    logic       exp_src;
  } vec_t;

  ent_t q[$];
  int   streak;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [1:0] v, input logic rdy,
                     input logic [1:0] er, input logic vo, input logic src);
    vec_t t;
    t.rst = r; t.v = v; t.rdy = rdy; t.exp_ready = er; t.exp_vo = vo; t.exp_src = src;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.lce_req_v_i = 2'b11;
    bus.lce_req_ready_and_i = 1'b1;
    #1;
    chk("rst.ready", 512'(bus.lce_req_ready_and_o), 512'(2'b00));
    chk("rst.v_o", 512'(bus.lce_req_v_o), 512'(1'b0));
    chk("rst.hdr", 512'(bus.lce_req_header_o), '0);
    bus.lce_req_v_i = 2'b00;
    bus.lce_req_ready_and_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    streak = 0;
  endtask

  // Reference: FIFO as a queue, streak as a plain integer, grant from the priority rule.
  task automatic model_check(input string tag);
    logic [1:0] v;
    logic       g1, g0;
    logic [1:0] er;
    ent_t       e;
    v  = bus.lce_req_v_i;
    g1 = v[1] && (!v[0] || streak < W);
    g0 = v[0] && !g1;
    er = (q.size() == 2) ? 2'b00 : {g1, g0};
    chk({tag, ".ready"}, 512'(bus.lce_req_ready_and_o), 512'(er));
    chk({tag, ".v_o"}, 512'(bus.lce_req_v_o), 512'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".hdr"}, 512'(bus.lce_req_header_o), 512'(q[0].hdr));
      chk({tag, ".data"}, bus.lce_req_data_o, q[0].data);
      chk({tag, ".src"}, 512'(bus.lce_req_src_o), 512'(q[0].src));
      if (bus.lce_req_ready_and_i) void'(q.pop_front());
    end
    if (er != 2'b00) begin
      e.src  = er[1];
      e.hdr  = bus.lce_req_header_i[er[1]];
      e.data = bus.lce_req_data_i[er[1]];
      q.push_back(e);
      if (er[1] && v[0]) streak = (streak >= W) ? W : streak + 1;
      else               streak = 0;
    end
  endtask

  initial begin
    logic [DW-1:0] dd;
    logic [DW-1:0] d0;

    bus.lce_req_v_i         = '0;
    bus.lce_req_ready_and_i = 1'b0;
    bus.lce_req_header_i    = '0;
    bus.lce_req_data_i      = '0;
    streak                  = 0;

    // contended stream D,D,I,D,D,I
    add(1, 2'b11, 1, 2'b10, 0, 0);
    add(0, 2'b11, 1, 2'b10, 1, 1);
    add(0, 2'b11, 1, 2'b01, 1, 1);
    add(0, 2'b11, 1, 2'b10, 1, 0);
    add(0, 2'b11, 1, 2'b10, 1, 1);
    add(0, 2'b11, 1, 2'b01, 1, 1);
    add(0, 2'b11, 1, 2'b10, 1, 0);
    add(0, 2'b00, 1, 2'b00, 1, 1);
    add(0, 2'b00, 1, 2'b00, 0, 0);
    // icache alone, back-to-back
    add(1, 2'b01, 1, 2'b01, 0, 0);
    add(0, 2'b01, 1, 2'b01, 1, 0);
    add(0, 2'b01, 1, 2'b01, 1, 0);
    add(0, 2'b01, 1, 2'b01, 1, 0);
    add(0, 2'b01, 1, 2'b01, 1, 0);
    add(0, 2'b00, 1, 2'b00, 1, 0);
    add(0, 2'b00, 1, 2'b00, 0, 0);
    // streak cleared by an uncontended dcache grant
    add(1, 2'b11, 1, 2'b10, 0, 0);
    add(0, 2'b10, 1, 2'b10, 1, 1);
    add(0, 2'b11, 1, 2'b10, 1, 1);
    add(0, 2'b11, 1, 2'b10, 1, 1);
    add(0, 2'b11, 1, 2'b01, 1, 1);
    add(0, 2'b00, 1, 2'b00, 1, 0);
    add(0, 2'b00, 1, 2'b00, 0, 0);
    // full FIFO refuses input even while dequeuing
    add(1, 2'b11, 0, 2'b10, 0, 0);
    add(0, 2'b11, 0, 2'b10, 1, 1);
    add(0, 2'b11, 0, 2'b00, 1, 1);
    add(0, 2'b11, 1, 2'b00, 1, 1);
    add(0, 2'b11, 1, 2'b01, 1, 1);
    add(0, 2'b00, 1, 2'b00, 1, 0);
    add(0, 2'b00, 1, 2'b00, 0, 0);

    bus.lce_req_header_i[0] = HW'(72'hA5A5);
    bus.lce_req_header_i[1] = HW'(72'hD1);
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      @(negedge clk);
      bus.lce_req_v_i         = tbl[i].v;
      bus.lce_req_ready_and_i = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d.ready", i), 512'(bus.lce_req_ready_and_o), 512'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d.v_o", i), 512'(bus.lce_req_v_o), 512'(tbl[i].exp_vo));
      if (tbl[i].exp_vo)
        chk($sformatf("tbl%0d.src", i), 512'(bus.lce_req_src_o), 512'(tbl[i].exp_src));
    end

    // backpressure: 0x11, 0x22 fill, ready returns the cycle after the first dequeue
    do_reset();
    @(negedge clk); bus.lce_req_v_i = 2'b01; bus.lce_req_header_i[0] = HW'(72'h11); #1;
    chk("bp.acc1", 512'(bus.lce_req_ready_and_o), 512'(2'b01));
    @(negedge clk); bus.lce_req_header_i[0] = HW'(72'h22); #1;
    chk("bp.acc2", 512'(bus.lce_req_ready_and_o), 512'(2'b01));
    @(negedge clk); bus.lce_req_header_i[0] = HW'(72'h33); #1;
    chk("bp.full", 512'(bus.lce_req_ready_and_o), 512'(2'b00));
    chk("bp.head1", 512'(bus.lce_req_header_o), 512'(72'h11));
    @(negedge clk); bus.lce_req_ready_and_i = 1'b1; #1;
    chk("bp.fulldeq", 512'(bus.lce_req_ready_and_o), 512'(2'b00));
    chk("bp.out1", 512'(bus.lce_req_header_o), 512'(72'h11));
    @(negedge clk); #1;
    chk("bp.ret", 512'(bus.lce_req_ready_and_o), 512'(2'b01));
    chk("bp.out2", 512'(bus.lce_req_header_o), 512'(72'h22));
    @(negedge clk); bus.lce_req_v_i = 2'b00; #1;
    chk("bp.out3", 512'(bus.lce_req_header_o), 512'(72'h33));
    @(negedge clk); #1;
    chk("bp.empty", 512'(bus.lce_req_v_o), 512'(1'b0));

    // asynchronous reset with two buffered entries
    do_reset();
    @(negedge clk); bus.lce_req_v_i = 2'b01; bus.lce_req_header_i[0] = HW'(72'h11);
    @(negedge clk); bus.lce_req_header_i[0] = HW'(72'h22);
    @(negedge clk); #1;
    chk("ar.pre_v", 512'(bus.lce_req_v_o), 512'(1'b1));
    rst_n = 1'b0; #1;
    chk("ar.v_o", 512'(bus.lce_req_v_o), 512'(1'b0));
    chk("ar.ready", 512'(bus.lce_req_ready_and_o), 512'(2'b00));
    chk("ar.hdr", 512'(bus.lce_req_header_o), '0);
    bus.lce_req_v_i = 2'b00; #1;
    rst_n = 1'b1;
    q.delete(); streak = 0;
    @(negedge clk); #1; chk("ar.idle1", 512'(bus.lce_req_v_o), 512'(1'b0));
    @(negedge clk); #1; chk("ar.idle2", 512'(bus.lce_req_v_o), 512'(1'b0));
    bus.lce_req_v_i = 2'b01; bus.lce_req_header_i[0] = HW'(72'h44); #1;
    chk("ar.acc", 512'(bus.lce_req_ready_and_o), 512'(2'b01));
    @(negedge clk); bus.lce_req_v_i = 2'b00; #1;
    chk("ar.new_v", 512'(bus.lce_req_v_o), 512'(1'b1));
    chk("ar.new_hdr", 512'(bus.lce_req_header_o), 512'(72'h44));

    // data integrity through both FIFO slots
    do_reset();
    dd = {16'hDEAD, {15{32'h0123_4567}}, 16'hBEEF};
    d0 = {16{32'h5A5A_C3C3}};
    @(negedge clk);
    bus.lce_req_v_i = 2'b11;
    bus.lce_req_header_i[1] = HW'(72'h1234); bus.lce_req_data_i[1] = dd;
    bus.lce_req_header_i[0] = HW'(72'hA5A5); bus.lce_req_data_i[0] = d0;
    #1; chk("di.g1", 512'(bus.lce_req_ready_and_o), 512'(2'b10));
    @(negedge clk); bus.lce_req_v_i = 2'b01; #1;
    chk("di.g0", 512'(bus.lce_req_ready_and_o), 512'(2'b01));
    @(negedge clk); bus.lce_req_v_i = 2'b00; bus.lce_req_ready_and_i = 1'b1; #1;
    chk("di.d_data", bus.lce_req_data_o, dd);
    chk("di.d_hdr", 512'(bus.lce_req_header_o), 512'(72'h1234));
    chk("di.d_src", 512'(bus.lce_req_src_o), 512'(1'b1));
    @(negedge clk); #1;
    chk("di.i_data", bus.lce_req_data_o, d0);
    chk("di.i_hdr", 512'(bus.lce_req_header_o), 512'(72'hA5A5));
    chk("di.i_src", 512'(bus.lce_req_src_o), 512'(1'b0));

    // random traffic against the queue model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      bus.lce_req_v_i         = 2'($urandom_range(0, 3));
      bus.lce_req_ready_and_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        bus.lce_req_header_i[k] = HW'({$urandom(), $urandom(), $urandom()});
        bus.lce_req_data_i[k]   = {16{$urandom()}};
      end
      #1;
      model_check("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
